// File: rtl/riscv_pkg.sv
// Shared types and constants for the single-core pipeline front end.
// Fetch FSM states, trap cause codes and the instruction size.
package riscv_pkg;

   typedef enum logic [1:0] {
      REQ    = 2'd0,
      WAIT   = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      TRAP_NONE             = 2'd0,
      TRAP_INSTR_MISALIGNED = 2'd1
   } trap_cause_t;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

   // Only bit 1 matters: bit 0 of a redirect target is dropped before use.
   function automatic logic target_misaligned(input logic [31:0] target);
      return target[1];
   endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the fetch PC, the imem request/response handshake and the
// decode-facing instruction register, and turns execute redirects into refetches.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid, once raised, holds together with its payload until that edge,
// except that a redirect may retarget or withdraw an unaccepted imem request.
module fetch_pc_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   input  logic        instr_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        halt,
   output logic        trap_valid,
   output logic [1:0]  trap_cause,
   output logic [31:0] trap_pc,
   output logic [1:0]  fsm_state
);

   fetch_state_t state_q;
   fetch_state_t state_d;
   logic [31:0]  fetch_pc_q;
   logic [31:0]  fetch_pc_d;
   logic         squash_q;
   logic         squash_d;

   logic         req_fire;
   logic         misaligned;
   logic [31:0]  redirect_pc;

   logic         imem_req_valid_d;
   logic [31:0]  imem_req_addr_d;
   logic         instr_valid_d;
   logic [31:0]  instr_d;
   logic [31:0]  pc_d;
   logic [31:0]  pc_plus4_d;
   logic         trap_valid_d;
   logic [1:0]   trap_cause_d;
   logic [31:0]  trap_pc_d;

   assign fsm_state = state_q;

   assign req_fire    = imem_req_valid & imem_req_ready;
   assign misaligned  = target_misaligned(redirect_target);
   assign redirect_pc = misaligned ? TRAP_VECTOR : {redirect_target[31:1], 1'b0};

   // State register; every output is also registered here from its _d value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= REQ;
         fetch_pc_q     <= RESET_VECTOR;
         squash_q       <= 1'b0;
         imem_req_valid <= 1'b0;
         imem_req_addr  <= RESET_VECTOR;
         instr_valid    <= 1'b0;
         instr          <= 32'h0;
         pc             <= RESET_VECTOR;
         pc_plus4       <= RESET_VECTOR + INSTR_BYTES;
         trap_valid     <= 1'b0;
         trap_cause     <= TRAP_NONE;
         trap_pc        <= 32'h0;
      end else begin
         state_q        <= state_d;
         fetch_pc_q     <= fetch_pc_d;
         squash_q       <= squash_d;
         imem_req_valid <= imem_req_valid_d;
         imem_req_addr  <= imem_req_addr_d;
         instr_valid    <= instr_valid_d;
         instr          <= instr_d;
         pc             <= pc_d;
         pc_plus4       <= pc_plus4_d;
         trap_valid     <= trap_valid_d;
         trap_cause     <= trap_cause_d;
         trap_pc        <= trap_pc_d;
      end
   end

   // Next state: a redirect beats every other same-cycle event.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      squash_d   = squash_q;
      case (state_q)
         REQ: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
               if (req_fire) begin
                  state_d  = WAIT;
                  squash_d = 1'b1;
               end
            end else if (req_fire) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
               if (imem_rsp_valid) begin
                  state_d  = REQ;
                  squash_d = 1'b0;
               end else begin
                  squash_d = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = halt ? HALTED : REQ;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
               state_d    = REQ;
            end else if (instr_ready) begin
               fetch_pc_d = fetch_pc_q + INSTR_BYTES;
               state_d    = halt ? HALTED : REQ;
            end
         end
         HALTED: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
            end
            if (!halt) begin
               state_d = REQ;
            end
         end
         default: begin
            state_d = REQ;
         end
      endcase
   end

   // Output values for the next cycle, derived from the transition being taken.
   always_comb begin
      imem_req_valid_d = (state_d == REQ);
      imem_req_addr_d  = fetch_pc_d;
      instr_valid_d    = (state_d == HOLD);
      instr_d          = instr;
      pc_d             = pc;
      if (state_q == WAIT && state_d == HOLD) begin
         instr_d = imem_rsp_data;
         pc_d    = fetch_pc_q;
      end
      pc_plus4_d   = pc_d + INSTR_BYTES;
      trap_valid_d = redirect_valid & misaligned;
      trap_cause_d = trap_cause;
      trap_pc_d    = trap_pc;
      if (redirect_valid && misaligned) begin
         trap_cause_d = TRAP_INSTR_MISALIGNED;
         trap_pc_d    = redirect_target;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: randomized imem/decode/execute traffic against a
// flag-based behavioural model, plus directed scenarios with literal expectations.
module tb_fetch_pc_unit;
   import riscv_pkg::*;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready = 1'b0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        halt = 1'b0;
   logic        trap_valid;
   logic [1:0]  trap_cause;
   logic [31:0] trap_pc;
   logic [1:0]  fsm_state;

   initial forever #5 clk = ~clk;

   fetch_pc_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .pc(pc), .pc_plus4(pc_plus4),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .halt(halt), .trap_valid(trap_valid), .trap_cause(trap_cause),
      .trap_pc(trap_pc), .fsm_state(fsm_state)
   );

   int checks = 0;
   int errors = 0;
   bit started = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   // ---------------- behavioural model ----------------
   // busy: a request is accepted and its response not yet seen; drop: that
   // response belongs to a path abandoned by a redirect.
   logic        m_req_valid, m_instr_valid, m_trap_valid;
   logic [31:0] m_target, m_instr, m_pc, m_trap_pc;
   logic [1:0]  m_trap_cause;
   bit          busy, drop, halted, fire, take, got;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_req_valid = 0; m_instr_valid = 0; m_trap_valid = 0;
         m_target = RV; m_instr = 0; m_pc = RV; m_trap_pc = 0; m_trap_cause = 0;
         busy = 0; drop = 0; halted = 0;
      end else begin
         fire = m_req_valid && imem_req_ready;
         take = m_instr_valid && instr_ready;
         got  = busy && imem_rsp_valid;
         m_trap_valid = 0;
         if (fire) busy = 1;
         if (redirect_valid) begin
            if (redirect_target[1]) begin
               m_target = TV;
               m_trap_valid = 1; m_trap_cause = 2'd1; m_trap_pc = redirect_target;
            end else begin
               m_target = redirect_target & 32'hFFFF_FFFE;
            end
            if (got) begin busy = 0; drop = 0; end
            else if (busy) drop = 1;
            m_instr_valid = 0;
            if (halted && !halt) halted = 0;
         end else if (got) begin
            busy = 0;
            if (drop) begin drop = 0; halted = halt; end
            else begin m_instr_valid = 1; m_instr = imem_rsp_data; m_pc = m_target; end
         end else if (take) begin
            m_instr_valid = 0; m_target = m_target + 32'd4; halted = halt;
         end else if (halted && !halt) begin
            halted = 0;
         end
         m_req_valid = !busy && !m_instr_valid && !halted;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (started) begin
         check("req_valid", 32'(imem_req_valid), 32'(m_req_valid));
         if (m_req_valid) check("req_addr", imem_req_addr, m_target);
         check("instr_valid", 32'(instr_valid), 32'(m_instr_valid));
         if (m_instr_valid) check("instr", instr, m_instr);
         check("pc", pc, m_pc);
         check("pc_plus4", pc_plus4, m_pc + 32'd4);
         check("trap_valid", 32'(trap_valid), 32'(m_trap_valid));
         if (m_trap_valid) begin
            check("trap_cause", 32'(trap_cause), 32'(m_trap_cause));
            check("trap_pc", trap_pc, m_trap_pc);
         end
      end
   end

   // ---------------- driver ----------------
   logic [31:0] req_log[$];
   logic [31:0] acc_pc[$];
   logic [31:0] acc_pc4[$];
   int ready_pct = 100, max_lat = 1, ir_pct = 100, rd_pct = 0, halt_pct = 0;
   bit ir_force = 0, ir_val = 1, rd_now = 0, rd_arm_wait = 0, halt_arm_wait = 0, halt_val = 0;
   logic [31:0] rd_tgt = 32'h0;
   bit outst = 0;
   logic [31:0] o_addr;
   int lat = 0;

   task automatic cycle();
      logic [31:0] t;
      @(negedge clk); #1;
      imem_rsp_valid = 0;
      imem_rsp_data  = $urandom;
      if (outst) begin
         if (lat == 0) begin
            imem_rsp_valid = 1; imem_rsp_data = mem_word(o_addr); outst = 0;
         end else lat--;
      end
      imem_req_ready = ($urandom_range(0, 99) < ready_pct);
      if (imem_req_valid && imem_req_ready) begin
         req_log.push_back(imem_req_addr);
         outst = 1; o_addr = imem_req_addr; lat = $urandom_range(0, max_lat - 1);
      end
      instr_ready = ir_force ? ir_val : ($urandom_range(0, 99) < ir_pct);
      if (instr_valid && instr_ready) begin
         acc_pc.push_back(pc); acc_pc4.push_back(pc_plus4);
      end
      redirect_valid = 0;
      if (rd_now || (rd_arm_wait && fsm_state == 2'(WAIT))) begin
         redirect_valid = 1; redirect_target = rd_tgt; rd_now = 0; rd_arm_wait = 0;
      end else if ($urandom_range(0, 99) < rd_pct) begin
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1] = 1'b0;
         redirect_valid = 1; redirect_target = t;
      end
      if (halt_arm_wait && fsm_state == 2'(WAIT)) begin halt_val = 1; halt_arm_wait = 0; end
      halt = (halt_pct > 0) ? ($urandom_range(0, 99) < halt_pct) : halt_val;
   endtask

   task automatic wait_req(input int n, input string name);
      int b = 0;
      while (req_log.size() <= n && b < 200) begin cycle(); b++; end
      if (req_log.size() <= n) begin
         checks++; errors++;
         $display("FAIL %s timeout waiting for request actual=none required=request", name);
      end
   endtask

   task automatic wait_acc(input int n, input string name);
      int b = 0;
      while (acc_pc.size() <= n && b < 200) begin cycle(); b++; end
      if (acc_pc.size() <= n) begin
         checks++; errors++;
         $display("FAIL %s timeout waiting for instr accept actual=none required=accept", name);
      end
   endtask

   task automatic wait_flag_clear(input string name);
      int b = 0;
      while ((rd_arm_wait || halt_arm_wait || rd_now) && b < 200) begin cycle(); b++; end
      if (rd_arm_wait || halt_arm_wait || rd_now) begin
         checks++; errors++;
         $display("FAIL %s timeout waiting for WAIT state actual=%0d required=%0d", name, fsm_state, 1);
      end
   endtask

   initial begin
      int n, na, b;
      #1 rst = 1;
      started = 1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc", pc, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h4);
      check("rst_trap", {29'h0, trap_valid, trap_cause}, 32'h0);
      check("rst_trap_pc", trap_pc, 32'h0);
      rst = 0;

      // sequential fetch, all ready, 1-cycle latency
      b = 0;
      while (acc_pc.size() < 3 && b < 100) begin cycle(); b++; end
      ir_force = 1; ir_val = 0;
      if (acc_pc.size() >= 3 && req_log.size() >= 3) begin
         check("seq_req0", req_log[0], 32'h0);
         check("seq_req1", req_log[1], 32'h4);
         check("seq_req2", req_log[2], 32'h8);
         check("seq_pc0", acc_pc[0], 32'h0);
         check("seq_pc2", acc_pc[2], 32'h8);
         check("seq_pc4_0", acc_pc4[0], 32'h4);
         check("seq_pc4_2", acc_pc4[2], 32'hC);
      end else begin
         checks++; errors++;
         $display("FAIL seq_count actual=%0d required=%0d", acc_pc.size(), 3);
      end

      // decode stall in HOLD
      b = 0;
      while (!instr_valid && b < 50) begin cycle(); b++; end
      repeat (5) cycle();
      check("hold_pc", pc, 32'hC);
      check("hold_instr", instr, mem_word(32'hC));
      check("hold_no_req", 32'(imem_req_valid), 32'd0);
      n = req_log.size();
      ir_val = 1; cycle(); ir_force = 0;
      wait_req(n, "hold_next");
      if (req_log.size() > n) check("hold_next_addr", req_log[n], 32'h10);

      // redirect while waiting for a response
      max_lat = 3; rd_tgt = 32'h200; rd_arm_wait = 1;
      wait_flag_clear("rd_wait");
      n = req_log.size(); na = acc_pc.size();
      wait_req(n, "rd_req");
      if (req_log.size() > n) check("rd_req_addr", req_log[n], 32'h200);
      wait_acc(na, "rd_acc");
      if (acc_pc.size() > na) check("rd_first_pc", acc_pc[na], 32'h200);

      // misaligned redirect -> trap
      rd_tgt = 32'h202; rd_now = 1; cycle();
      n = req_log.size();
      cycle();
      check("trap_valid_lit", 32'(trap_valid), 32'd1);
      check("trap_cause_lit", 32'(trap_cause), 32'd1);
      check("trap_pc_lit", trap_pc, 32'h202);
      wait_req(n, "trap_req");
      if (req_log.size() > n) check("trap_req_addr", req_log[n], 32'h100);

      // wrap at the top of the address space
      max_lat = 1; rd_tgt = 32'hFFFF_FFFC; rd_now = 1; cycle();
      n = req_log.size(); na = acc_pc.size();
      wait_req(n, "wrap_req");
      if (req_log.size() > n) check("wrap_req_addr", req_log[n], 32'hFFFF_FFFC);
      wait_acc(na, "wrap_acc");
      if (acc_pc.size() > na) begin
         check("wrap_pc", acc_pc[na], 32'hFFFF_FFFC);
         check("wrap_pc_plus4", acc_pc4[na], 32'h0);
      end
      wait_req(n + 1, "wrap_next");
      if (req_log.size() > n + 1) check("wrap_next_addr", req_log[n + 1], 32'h0);

      // halt during WAIT, redirect while halted, resume
      max_lat = 2; halt_arm_wait = 1;
      wait_flag_clear("halt_wait");
      na = acc_pc.size();
      wait_acc(na, "halt_deliver");
      n = req_log.size();
      repeat (6) cycle();
      check("halt_no_req", 32'(req_log.size()), 32'(n));
      check("halt_state", 32'(fsm_state), 32'(HALTED));
      rd_tgt = 32'h40; rd_now = 1;
      repeat (3) cycle();
      check("halt_rd_no_req", 32'(req_log.size()), 32'(n));
      halt_val = 0;
      wait_req(n, "halt_resume");
      if (req_log.size() > n) check("halt_resume_addr", req_log[n], 32'h40);

      // randomized traffic
      ready_pct = 70; max_lat = 4; ir_pct = 70; rd_pct = 5; halt_pct = 10;
      repeat (3000) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
